// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII console blocks: character constants,
// the word streamer state encoding and a digit-count helper.
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_e;

  // Number of hex digits needed to print a word of w bits (top nibble zero-padded).
  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to ASCII digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
// Used for both binary (bit zero-extended) and hex digits.
module nibble_to_ascii
  import ascii_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  // Select the decimal or uppercase-letter range and offset into it.
  always_comb begin
    ch = 8'h00;
    if (nib < 4'd10) begin
      ch = ASCII_ZERO + {4'b0000, nib};
    end else begin
      ch = ASCII_UPPER_A + ({4'b0000, nib} - 8'd10);
    end
  end

endmodule

// File: rtl/ascii_word_streamer.sv
// Accepts a WIDTH-bit word over valid/ready and streams it out MSB first as
// ASCII binary or uppercase hex digits, optionally followed by CR LF.
// All outputs are registered; they are loaded from the next-state values so
// the first character appears the cycle after the word is accepted.
module ascii_word_streamer
  import ascii_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_hex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NDIG_HEX = hex_digits(WIDTH);
  localparam int PADW     = 4 * NDIG_HEX;
  localparam int IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_r, state_nxt_s;
  logic [IDXW-1:0]   idx_r, idx_nxt_s;
  logic [WIDTH-1:0]  data_r, data_nxt_s;
  logic              hex_r, hex_nxt_s;
  logic              xfer_s;
  logic [PADW-1:0]   pad_data_s;
  logic [3:0]        digit_nib_s;
  logic [7:0]        digit_char_s;
  logic [7:0]        char_nxt_s;
  logic              last_nxt_s;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [7:0]        out_char_r;
  logic              out_last_r;
  logic              busy_r;

  assign xfer_s    = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_char  = out_char_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

  // Next-state logic: accept in IDLE, walk digits down to index 0, then terminator.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = data_r;
    hex_nxt_s   = hex_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nxt_s = DIGIT;
          data_nxt_s  = in_data;
          hex_nxt_s   = in_hex;
          if (in_hex) begin
            idx_nxt_s = IDXW'(NDIG_HEX - 1);
          end else begin
            idx_nxt_s = IDXW'(WIDTH - 1);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIGIT: begin
        if (xfer_s) begin
          if (idx_r == {IDXW{1'b0}}) begin
            state_nxt_s = APPEND_NEWLINE ? CR : IDLE;
          end else begin
            idx_nxt_s = idx_r - IDXW'(1);
          end
        end else begin
          state_nxt_s = DIGIT;
        end
      end
      CR: begin
        if (xfer_s) begin
          state_nxt_s = LF;
        end else begin
          state_nxt_s = CR;
        end
      end
      LF: begin
        if (xfer_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LF;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pick the digit value at the next index from the (possibly new) latched word.
  always_comb begin
    pad_data_s              = {PADW{1'b0}};
    pad_data_s[WIDTH-1:0]   = data_nxt_s;
    if (hex_nxt_s) begin
      digit_nib_s = pad_data_s[int'(idx_nxt_s) * 4 +: 4];
    end else begin
      digit_nib_s = {3'b000, data_nxt_s[idx_nxt_s]};
    end
  end

  nibble_to_ascii u_nib (
    .nib (digit_nib_s),
    .ch  (digit_char_s)
  );

  // Character and last flag to present once the FSM reaches its next state.
  always_comb begin
    char_nxt_s = 8'h00;
    last_nxt_s = 1'b0;
    case (state_nxt_s)
      DIGIT: begin
        char_nxt_s = digit_char_s;
        last_nxt_s = !APPEND_NEWLINE && (idx_nxt_s == {IDXW{1'b0}});
      end
      CR: begin
        char_nxt_s = ASCII_CR;
        last_nxt_s = 1'b0;
      end
      LF: begin
        char_nxt_s = ASCII_LF;
        last_nxt_s = 1'b1;
      end
      default: begin
        char_nxt_s = 8'h00;
        last_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched word, mode, digit index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= {IDXW{1'b0}};
      data_r      <= {WIDTH{1'b0}};
      hex_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_char_r  <= 8'h00;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      data_r      <= data_nxt_s;
      hex_r       <= hex_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s != IDLE);
      out_char_r  <= char_nxt_s;
      out_last_r  <= last_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: doc/ascii_word_streamer.md
Name: ascii_word_streamer

Overview:
Parametrised successor to the single-bit ASCII converter. Accepts a WIDTH-bit word over a valid/ready handshake and streams it out one ASCII character per cycle, MSB first. Output is binary ('0'/'1') or uppercase hex, selected per word, with an optional CR LF terminator. Sits between the datapath and the UART TX / debug console path.

Parameters:
WIDTH, 8, data word width in bits (>=1)
APPEND_NEWLINE, 1, 1 = emit 8'h0D then 8'h0A after the last digit; 0 = digits only

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_data/in_hex are valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to convert
in_hex  input  1  0 = binary digits, 1 = hex digits; sampled at accept
out_valid  output  1  out_char is valid
out_ready  input  1  downstream accepts out_char
out_char  output  8  ASCII character
out_last  output  1  marks the final character of the word
busy  output  1  high from accept until the final character is accepted

Behaviour:
- Reset (async assert): state=IDLE, in_ready=1, out_valid=0, out_char=8'h00, out_last=0, busy=0. Deassertion is used synchronously.
- Digit count: binary NDIG=WIDTH; hex NDIG=ceil(WIDTH/4). Hex zero-pads the top nibble, e.g. WIDTH=10 gives 3 digits.
- Digit mapping: 0-9 -> 8'h30-8'h39; 10-15 -> 8'h41-8'h46 (uppercase). A binary digit maps the same way with the bit zero-extended.
- FSM states: IDLE, DIGIT, CR, LF.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_hex, set digit index to NDIG-1, go to DIGIT.
  - DIGIT: present the digit at the current index.
  - On out_valid&&out_ready: decrement the index. At index 0, go to CR if APPEND_NEWLINE=1, else go to IDLE.
  - CR: present 8'h0D. On transfer, go to LF.
  - LF: present 8'h0A with out_last=1. On transfer, go to IDLE.
  - With APPEND_NEWLINE=0, out_last=1 on the index-0 digit.
- Latency: accept in cycle N gives the first out_valid in cycle N+1. All outputs are registered.
- Throughput: one character per cycle while out_ready=1. in_ready returns high the cycle after the final transfer, so there is one bubble cycle between words.
- Backpressure: while out_valid && !out_ready, out_char and out_last hold stable and the state does not advance. out_valid never drops without a transfer.
- in_ready=0 in every non-IDLE state. in_valid during a word is ignored, not queued.
- Inputs change after accept: no effect; the latched copy is used.
- Reset mid-word: the word is discarded, outputs return to reset values immediately, and there is no partial terminator.
- busy = (state != IDLE).

Decomposition:
- Package ascii_pkg:
  - constants ASCII_ZERO=8'h30, ASCII_UPPER_A=8'h41, ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - state enum {IDLE, DIGIT, CR, LF}
- Sub-module nibble_to_ascii: combinational, 4-bit in, 8-bit ASCII out. It is shared by binary and hex mode and is reusable by other console blocks.

Test Plan:
- WIDTH=8, binary, in_data=8'hA5, out_ready=1 -> chars 31 30 31 30 30 31 30 31 0D 0A on consecutive cycles; out_last only on 0A; first char in cycle after accept.
- WIDTH=8, hex, 8'hA5 then 8'h00 back-to-back -> 41 35 0D 0A, one bubble, then 30 30 0D 0A; in_ready low throughout each word.
- WIDTH=10, hex, 10'h3FF, APPEND_NEWLINE=0 -> 33 46 46; out_last on the second 46; in_ready high the next cycle.
- Backpressure: hex 8'h3C, out_ready low for 3 cycles on the first digit and 2 cycles on CR -> 33 then 43 0D 0A with no loss or duplication; out_char stable while stalled.
- Reset asserted during the second binary digit of 8'hFF -> out_valid/busy drop asynchronously, in_ready=1. Next word 8'h01 binary -> 30 30 30 30 30 30 30 31 0D 0A.
- in_valid pulsed with 8'h77 while busy -> ignored; only the original word is emitted.
